// File: rtl/fetch_buffer.sv
// In-order instruction fetch queue between the PC register, instruction memory and decode.
// Define FETCH_BUF_BYPASS_EN to forward a returning response straight to decode when it fills the queue head.
module fetch_buffer #(
    parameter int PC_WIDTH   = 32,
    parameter int INST_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_en,
    input  logic [PC_WIDTH-1:0]   pc,
    input  logic                  redirect,
    output logic                  pc_stall,
    output logic                  imem_req_valid,
    output logic [PC_WIDTH-1:0]   imem_req_addr,
    input  logic                  imem_req_ready,
    input  logic                  imem_resp_valid,
    input  logic [INST_WIDTH-1:0] imem_resp_inst,
    output logic                  dec_valid,
    output logic [INST_WIDTH-1:0] dec_inst,
    output logic [PC_WIDTH-1:0]   dec_pc,
    input  logic                  dec_ready
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [PC_WIDTH-1:0]   pc_mem   [DEPTH];
    logic [INST_WIDTH-1:0] inst_mem [DEPTH];
    logic [DEPTH-1:0]      filled;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] fill_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] alloc_cnt;
    // pend_cnt = allocated but not yet filled; kept explicitly because
    // wr_ptr == fill_ptr is ambiguous between empty and all-outstanding.
    logic [CW-1:0] pend_cnt;
    logic [CW-1:0] drop_cnt;

    logic          flush;
    logic          accept;
    logic          drop_hit;
    logic          fill_hit;
    logic          head_filled;
    logic          bypass_hit;
    logic          deq;
    logic [CW-1:0] drop_total;
    logic [CW-1:0] flush_drop;
    logic [CW-1:0] alloc_next;
    logic [CW-1:0] pend_next;

    always_comb begin
        flush          = cpu_en & redirect;
        imem_req_valid = cpu_en & ~redirect & (alloc_cnt < FULL) & (drop_cnt == '0);
        imem_req_addr  = pc;
        accept         = imem_req_valid & imem_req_ready;
        pc_stall       = ~accept;

        drop_hit    = imem_resp_valid & (drop_cnt != '0);
        fill_hit    = imem_resp_valid & (drop_cnt == '0) & (pend_cnt != '0);
        head_filled = filled[rd_ptr];
`ifdef FETCH_BUF_BYPASS_EN
        bypass_hit  = fill_hit & (fill_ptr == rd_ptr) & ~head_filled;
`else
        bypass_hit  = 1'b0;
`endif

        dec_valid = cpu_en & ~redirect & (head_filled | bypass_hit);
        dec_inst  = bypass_hit ? imem_resp_inst : inst_mem[rd_ptr];
        dec_pc    = pc_mem[rd_ptr];
        deq       = dec_valid & dec_ready;

        // A response in the flush cycle belongs to the old stream and retires one drop.
        drop_total = drop_cnt + pend_cnt;
        flush_drop = (imem_resp_valid && (drop_total != '0)) ? (drop_total - CNT_ONE) : drop_total;

        alloc_next = alloc_cnt;
        if (accept && !deq) begin
            alloc_next = alloc_cnt + CNT_ONE;
        end else if (!accept && deq) begin
            alloc_next = alloc_cnt - CNT_ONE;
        end

        pend_next = pend_cnt;
        if (accept && !fill_hit) begin
            pend_next = pend_cnt + CNT_ONE;
        end else if (!accept && fill_hit) begin
            pend_next = pend_cnt - CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            fill_ptr  <= '0;
            rd_ptr    <= '0;
            alloc_cnt <= '0;
            pend_cnt  <= '0;
            drop_cnt  <= '0;
            filled    <= '0;
        end else if (flush) begin
            wr_ptr    <= '0;
            fill_ptr  <= '0;
            rd_ptr    <= '0;
            alloc_cnt <= '0;
            pend_cnt  <= '0;
            drop_cnt  <= flush_drop;
            filled    <= '0;
        end else begin
            if (accept) begin
                filled[wr_ptr] <= 1'b0;
                wr_ptr         <= wr_ptr + PTR_ONE;
            end
            if (fill_hit) begin
                // A bypassed entry consumed this cycle never becomes filled.
                if (!(bypass_hit && deq)) begin
                    filled[fill_ptr] <= 1'b1;
                end
                fill_ptr <= fill_ptr + PTR_ONE;
            end
            if (deq) begin
                if (!bypass_hit) begin
                    filled[rd_ptr] <= 1'b0;
                end
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (drop_hit) begin
                drop_cnt <= drop_cnt - CNT_ONE;
            end
            alloc_cnt <= alloc_next;
            pend_cnt  <= pend_next;
        end
    end

    // Payload storage needs no reset; filled bits gate every use of it.
    always_ff @(posedge clk) begin
        if (accept) begin
            pc_mem[wr_ptr] <= pc;
        end
        if (fill_hit && !flush) begin
            inst_mem[fill_ptr] <= imem_resp_inst;
        end
    end

endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

Front-end fetch block on the consumer side of the PC register. Each cycle it turns the current `pc` into an instruction-memory request and drives `pc_stall` back so the PC advances only when a request is accepted. It holds up to DEPTH in-flight or returned instructions in order and hands them to decode with a valid/ready handshake. It flushes on any redirect (trap, mret/ecall/ebreak commit, branch or jump taken), dropping wrong-path responses still in flight.

## Interface

- PC_WIDTH, 32, width of fetch address
- INST_WIDTH, 32, instruction width
- DEPTH, 4, queue entries; power of two, ≥2
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- cpu_en  in  1  global enable, same signal the PC register sees
- pc  in  PC_WIDTH  current fetch PC from the PC register
- redirect  in  1  OR of trap_happened, ctrl-PC commit, br_taken, jp_taken (same cycle the PC register loads its target)
- pc_stall  out  1  to PC register; 1 = hold pc
- imem_req_valid  out  1  fetch request
- imem_req_addr  out  PC_WIDTH  equals `pc`
- imem_req_ready  in  1  memory accepts request this cycle
- imem_resp_valid  in  1  in-order response; memory cannot be back-pressured
- imem_resp_inst  in  INST_WIDTH  response data
- dec_valid  out  1  head instruction available
- dec_inst  out  INST_WIDTH  head instruction
- dec_pc  out  PC_WIDTH  PC of head instruction
- dec_ready  in  1  decode accepts head

## Operation

- Circular queue, DEPTH entries of {pc, inst, filled}; pointers: wr (allocate), fill, rd; alloc_cnt 0..DEPTH; drop_cnt 0..DEPTH.
- imem_req_valid = cpu_en & !redirect & (alloc_cnt < DEPTH) & (drop_cnt == 0). The request is combinational; valid may fall without ready, and memory samples only on valid & ready.
- Accept (valid & ready): write pc into entry[wr], filled=0, wr++, alloc_cnt++.
- pc_stall = !(imem_req_valid & imem_req_ready).
- Response: if drop_cnt != 0, discard and decrement drop_cnt. Otherwise write inst into entry[fill], set filled, fill++. A response when nothing is outstanding is ignored.
- dec_valid = cpu_en & !redirect & entry[rd].filled. dec_pc/dec_inst come from entry[rd]. On dec_valid & dec_ready: clear filled, rd++, alloc_cnt--.
- Flush (redirect & cpu_en):
  - wr = fill = rd = 0, alloc_cnt = 0, all filled cleared.
  - drop_cnt_next = drop_cnt + unfilled_cnt − imem_resp_valid, where unfilled_cnt = entries allocated but not filled. A same-cycle response counts as old-stream.
  - No request and no dequeue in that cycle.
- cpu_en=0: no request (pc_stall=1), no dequeue, redirect ignored. Responses are still absorbed per the rules above.
- Accept, fill and dequeue may all occur in one cycle; alloc_cnt nets the changes.

## Timing

- Reset values: all pointers 0, alloc_cnt 0, drop_cnt 0, all filled 0, dec_valid 0. imem_req_valid = cpu_en (queue empty), imem_req_addr = pc.
- Request accepted in cycle T; response earliest T+1; dec_valid earliest T+2 (registered fill, base build).
- Full (alloc_cnt == DEPTH): request blocked, pc_stall=1 until a dequeue. Dequeue in cycle T frees a slot for a request at T+1.
- After flush at T: PC register holds the target at T+1. A request issues at T+1 only if drop_cnt == 0, otherwise after the last drop.
- Reset asserted mid-operation clears all state immediately; responses arriving after reset release are treated as new-stream data. Memory must also be reset.

## Configuration

- FETCH_BUF_BYPASS_EN defined: when the queue head is the entry being filled and drop_cnt == 0, dec_valid/dec_inst are taken from imem_resp_inst in the response cycle. Fill-to-decode latency becomes 0, so request-to-decode is T+1. If dec_ready is asserted, the entry is consumed without being marked filled.
- Undefined: no bypass. Decode sees the instruction one cycle after its response.

## Test plan

- Reset, cpu_en=1, ready=1, 1-cycle memory latency, dec_ready=1, pc 0,4,8,… -> one request per cycle. dec_pc 0x0 at cycle 2, then consecutive words; pc_stall stays 0.
- dec_ready=0, DEPTH=4 -> after 4 accepts imem_req_valid=0 and pc_stall=1. One dequeue -> exactly one more request the next cycle.
- 3 requests outstanding, redirect in the cycle the first response arrives -> drop_cnt=2. The next 2 responses are discarded; the first new request (target pc 0x100) issues after them; dec_pc=0x100.
- imem_req_ready low for 3 cycles -> pc_stall=1 for those cycles, imem_req_addr stable, no allocation.
- cpu_en=0 with 2 outstanding -> both responses fill, dec_valid=0, no requests. cpu_en=1 -> both dequeue in order.
- Bypass build, empty queue, response with dec_ready=1 -> dec_valid and dec_inst in the same cycle, alloc_cnt returns to 0. Base build -> one cycle later.
